// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin arbiter for four requesters sharing one 1-bit 4:1 mux path.
//
// Ports:
//   clk    - rising-edge clock for all state
//   rst_n  - synchronous active-low reset
//   req    - request lines, bit i = requester i wants the path
//   in0-3  - requester data bits
//   gnt    - registered one-hot grant, zero when there is no owner
//   sel    - registered mux select, index of current or last owner
//   out    - in[sel] while gnt is nonzero, else 0
//   busy   - registered, high in GRANT or GAP
//
// Optional feature: define MUX_ARB_TIMEOUT_EN to force an owner off the path after
// HOLD_MAX grant cycles when another requester is waiting. Without it HOLD_MAX is unused.

module mux4_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       out,
  output logic       busy
);

  if ((HOLD_MAX == 0) || (HOLD_MAX > 255)) begin : g_hold_range
    $error("mux4_arbiter: HOLD_MAX must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       busy_q;
  logic [1:0] win;
  logic       grant_new;
  logic       timeout;

  // Round-robin pick: scan from ptr upward with wrap. Descending loop so the
  // smallest offset from ptr is the last (winning) assignment.
  always_comb begin
    logic [1:0] idx;
    win = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) win = idx;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic [7:0] hold_inc;

  assign hold_inc = (hold_q == 8'(HOLD_MAX)) ? hold_q : hold_q + 8'd1;
  // Release when this grant cycle is the HOLD_MAX-th and someone else is waiting.
  assign timeout  = (hold_inc == 8'(HOLD_MAX)) && |(req & ~gnt_q);

  // Cleared whenever the next cycle is not a continued grant, so it restarts
  // at zero on every entry into GRANT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if ((state_q == StGrant) && (state_d == StGrant)) begin
      hold_q <= hold_inc;
    end else begin
      hold_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    grant_new = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) grant_new = 1'b1;
      end
      StGrant: begin
        // sel_q is the owner's index while in GRANT.
        if (!req[sel_q] || timeout) begin
          state_d = StGap;
          gnt_d   = '0;
        end
      end
      StGap: begin
        if (|req) grant_new = 1'b1;
        else      state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
    if (grant_new) begin
      state_d = StGrant;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      ptr_d   = win + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  always_comb begin
    out = 1'b0;
    if (|gnt_q) begin
      unique case (sel_q)
        2'd0:    out = in0;
        2'd1:    out = in1;
        2'd2:    out = in2;
        default: out = in3;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Testbench for mux4_arbiter: behavioural model feeds a scoreboard queue, plus directed
// checks against fixed grant sequences. Honours MUX_ARB_TIMEOUT_EN if defined.

module tb_mux4_arbiter;

  localparam int unsigned Hold = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       in0, in1, in2, in3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out;
  logic       busy;

  mux4_arbiter #(.HOLD_MAX(Hold)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .gnt   (gnt),
    .sel   (sel),
    .out   (out),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: 0 idle, 1 grant, 2 gap.
  int         m_st   = 0;
  logic [3:0] m_gnt  = '0;
  int         m_sel  = 0;
  int         m_ptr  = 0;
  int         m_hold = 0;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic pick(input logic [3:0] r);
    bit found = 0;
    for (int i = 0; i < 4; i++) begin
      int idx = (m_ptr + i) % 4;
      if (!found && r[idx]) begin
        found  = 1;
        m_st   = 1;
        m_gnt  = 4'(1 << idx);
        m_sel  = idx;
        m_ptr  = (idx + 1) % 4;
        m_hold = 0;
      end
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic rn);
    exp_t e;
    bit   rel;
    if (!rn) begin
      m_st = 0; m_gnt = '0; m_sel = 0; m_ptr = 0; m_hold = 0;
    end else begin
      case (m_st)
        0: if (r != 0) pick(r);
        1: begin
          if (m_hold < Hold) m_hold++;
          rel = !r[m_sel];
`ifdef MUX_ARB_TIMEOUT_EN
          if (m_hold >= Hold && (r & ~m_gnt) != 0) rel = 1;
`endif
          if (rel) begin
            m_st  = 2;
            m_gnt = '0;
          end
        end
        default: if (r != 0) pick(r); else m_st = 0;
      endcase
    end
    e.gnt  = m_gnt;
    e.sel  = 2'(m_sel);
    e.busy = (m_st != 0);
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic [3:0] r, input logic rn);
    exp_t       e;
    logic [3:0] ins;
    req   = r;
    rst_n = rn;
    {in3, in2, in1, in0} = 4'($urandom);
    model_step(r, rn);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    ins = {in3, in2, in1, in0};
    check_eq("sb_gnt", gnt, e.gnt);
    check_eq("sb_sel", {2'b0, sel}, {2'b0, e.sel});
    check_eq("sb_busy", {3'b0, busy}, {3'b0, e.busy});
    check_eq("sb_out", {3'b0, out}, {3'b0, (|e.gnt) ? ins[e.sel] : 1'b0});
    check_eq("onehot", {3'b0, $onehot0(gnt)}, 4'd1);
  endtask

  logic [3:0] pat [11];
  logic [3:0] r;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    {in3, in2, in1, in0} = '0;

    // Reset with requests present: requests ignored.
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    check_eq("rst_gnt", gnt, 4'b0000);
    check_eq("rst_sel", {2'b0, sel}, 4'd0);
    check_eq("rst_busy", {3'b0, busy}, 4'd0);
    check_eq("rst_out", {3'b0, out}, 4'd0);

    // All four request from idle -> index 0.
    cycle(4'b0000, 1'b1);
    cycle(4'b1111, 1'b1);
    check_eq("all4_gnt", gnt, 4'b0001);
    check_eq("all4_sel", {2'b0, sel}, 4'd0);
    check_eq("all4_busy", {3'b0, busy}, 4'd1);
    check_eq("all4_out", {3'b0, out}, {3'b0, in0});
    cycle(4'b1111, 1'b1);
    cycle(4'b1111, 1'b1);
    check_eq("hold_gnt", gnt, 4'b0001);

    // Rotation with a GAP between every owner change.
    cycle(4'b1110, 1'b1);
    check_eq("gap0_gnt", gnt, 4'b0000);
    check_eq("gap0_out", {3'b0, out}, 4'd0);
    check_eq("gap0_busy", {3'b0, busy}, 4'd1);
    cycle(4'b1110, 1'b1);
    check_eq("rr1_gnt", gnt, 4'b0010);
    check_eq("rr1_sel", {2'b0, sel}, 4'd1);
    cycle(4'b1101, 1'b1);
    check_eq("gap1_gnt", gnt, 4'b0000);
    cycle(4'b1101, 1'b1);
    check_eq("rr2_gnt", gnt, 4'b0100);
    cycle(4'b1011, 1'b1);
    cycle(4'b1011, 1'b1);
    check_eq("rr3_gnt", gnt, 4'b1000);
    cycle(4'b0111, 1'b1);
    check_eq("gap3_gnt", gnt, 4'b0000);
    cycle(4'b0111, 1'b1);
    check_eq("wrap_gnt", gnt, 4'b0001);

    // Reset mid-grant of owner 2: grant dropped on the same edge.
    cycle(4'b0100, 1'b1);
    cycle(4'b0100, 1'b1);
    check_eq("own2_gnt", gnt, 4'b0100);
    cycle(4'b0100, 1'b0);
    check_eq("midrst_gnt", gnt, 4'b0000);
    check_eq("midrst_sel", {2'b0, sel}, 4'd0);
    check_eq("midrst_busy", {3'b0, busy}, 4'd0);
    cycle(4'b0100, 1'b1);
    check_eq("postrst_gnt", gnt, 4'b0100);

    // Single one-cycle pulse: grant, gap, idle.
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b1000, 1'b1);
    check_eq("pulse_gnt", gnt, 4'b1000);
    cycle(4'b0000, 1'b1);
    check_eq("pulse_gap", gnt, 4'b0000);
    check_eq("pulse_gapbusy", {3'b0, busy}, 4'd1);
    cycle(4'b0000, 1'b1);
    check_eq("pulse_idle", {3'b0, busy}, 4'd0);

    // Two steady requesters; ptr is 0 here so owner 0 wins first.
    cycle(4'b0011, 1'b1);
    check_eq("two_first", gnt, 4'b0001);
`ifdef MUX_ARB_TIMEOUT_EN
    pat = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
            4'b0000, 4'b0001, 4'b0001};
    for (int i = 0; i < 11; i++) begin
      cycle(4'b0011, 1'b1);
      check_eq("tmo_seq", gnt, pat[i]);
    end
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0001, 1'b1);
      check_eq("tmo_alone", gnt, 4'b0001);
    end
`else
    pat = '{default: 4'b0001};
    for (int i = 0; i < 110; i++) begin
      cycle(4'b0011, 1'b1);
      check_eq("notmo_hold", gnt, pat[i % 11]);
    end
`endif

    // Random sticky requests with occasional reset.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cycle(r, ($urandom_range(0, 39) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
